// File: rtl/lcd_line_fetch.sv
`default_nettype none
// ============================================================================
// Module   : lcd_line_fetch
// Brief    : Burst pixel prefetcher with FIFO feeding the RGB LCD timing driver.
// Revision : 1.0 - initial release
// ============================================================================
module lcd_line_fetch #(
  parameter int          ADDR_W          = 28,
  parameter int          FIFO_DEPTH      = 512,
  parameter int          BURST_LEN       = 64,
  parameter logic [23:0] UNDERFLOW_COLOR = 24'h000000
) (
  input  logic              lcd_pclk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] frame_base,
  input  logic [10:0]       h_disp,
  input  logic [10:0]       v_disp,
  input  logic              data_req,
  input  logic [10:0]       pixel_ypos,
  output logic [23:0]       pixel_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_len,
  input  logic              rd_grant,
  input  logic              rd_valid,
  input  logic [23:0]       rd_data,
  output logic              synced,
  output logic              underflow,
  input  logic              err_clr
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_DATA   = 2'd2,
    S_RESYNC = 2'd3
  } state_t;

  state_t              r_state;
  logic                r_rd_req;
  logic [ADDR_W-1:0]   r_rd_addr;
  logic [7:0]          r_rd_len;
  logic [7:0]          r_beats_left;
  logic                r_rs_req;
  logic [20:0]         r_fetched;
  logic [20:0]         r_consumed;
  logic [ADDR_W-1:0]   r_frame_base_q;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic [23:0]         r_mem [FIFO_DEPTH];
  logic [23:0]         r_pixel_data;
  logic                r_synced;
  logic                r_underflow;
  logic                r_data_req_d;

  logic [20:0]         w_frame_pix;
  logic [20:0]         w_remain;
  logic [7:0]          w_next_len;
  logic [c_CNT_W-1:0]  w_free;
  logic                w_can_issue;
  logic [ADDR_W-1:0]   w_base;
  logic                w_frame_start;
  logic                w_sync_now;
  logic                w_misalign;
  logic                w_active;
  logic                w_empty;
  logic                w_underflow;
  logic                w_pop;
  logic                w_push;
  logic                w_frame_end;
  logic                w_flush;

  assign w_frame_pix = 21'(h_disp) * 21'(v_disp);
  assign w_remain    = w_frame_pix - r_fetched;
  assign w_next_len  = (w_remain > 21'(BURST_LEN)) ? 8'(BURST_LEN) : w_remain[7:0];
  assign w_free      = c_CNT_W'(FIFO_DEPTH) - r_count;
  assign w_can_issue = fetch_en && (r_fetched < w_frame_pix) &&
                       (32'(w_free) >= 32'(w_next_len));
  // The base latch and the first request of a frame can coincide; bypass it.
  assign w_base      = (r_fetched == '0) ? frame_base : r_frame_base_q;

  // The frame-start data_req is itself served, so sync takes effect this cycle.
  assign w_frame_start = data_req && !r_data_req_d && (pixel_ypos == 11'd1);
  assign w_sync_now    = w_frame_start && fetch_en && !r_synced && (r_state != S_RESYNC);
  assign w_misalign    = w_frame_start && fetch_en && r_synced && (r_consumed != '0);
  assign w_active      = r_synced || w_sync_now;
  assign w_empty       = (r_count == '0);
  assign w_underflow   = (data_req && w_active && w_empty) || w_misalign;
  assign w_pop         = data_req && w_active && !w_empty && !w_misalign;
  assign w_frame_end   = w_pop && ((r_consumed + 21'd1) == w_frame_pix);
  assign w_push        = (r_state == S_DATA) && rd_valid;
  assign w_flush       = ((r_state == S_IDLE) && !fetch_en) ||
                         ((r_state == S_RESYNC) && !r_rs_req && (r_beats_left == '0));

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_rd_req       <= 1'b0;
      r_rd_addr      <= '0;
      r_rd_len       <= '0;
      r_beats_left   <= '0;
      r_rs_req       <= 1'b0;
      r_fetched      <= '0;
      r_frame_base_q <= '0;
    end else begin
      if (r_fetched == '0) r_frame_base_q <= frame_base;
      case (r_state)
        S_IDLE: begin
          if (w_underflow) begin
            r_state <= S_RESYNC;
          end else if (w_can_issue) begin
            r_rd_req  <= 1'b1;
            r_rd_addr <= w_base + ADDR_W'(r_fetched);
            r_rd_len  <= w_next_len;
            r_state   <= S_REQ;
          end
        end
        S_REQ: begin
          if (rd_grant) begin
            r_rd_req     <= 1'b0;
            r_beats_left <= r_rd_len;
            r_state      <= w_underflow ? S_RESYNC : S_DATA;
          end else if (w_underflow) begin
            // Request stays up; the burst must still be granted and drained.
            r_rs_req <= 1'b1;
            r_state  <= S_RESYNC;
          end
        end
        S_DATA: begin
          if (rd_valid) r_beats_left <= r_beats_left - 8'd1;
          if (w_underflow) begin
            r_state <= S_RESYNC;
          end else if (rd_valid && (r_beats_left == 8'd1)) begin
            r_fetched <= r_fetched + 21'(r_rd_len);
            r_state   <= S_IDLE;
          end
        end
        S_RESYNC: begin
          if (r_rs_req) begin
            if (rd_grant) begin
              r_rs_req     <= 1'b0;
              r_rd_req     <= 1'b0;
              r_beats_left <= r_rd_len;
            end
          end else if (r_beats_left != '0) begin
            if (rd_valid) r_beats_left <= r_beats_left - 8'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_flush || w_frame_end) r_fetched <= '0;
    end
  end

  always_ff @(posedge lcd_pclk) begin
    if (w_push) r_mem[r_wr_ptr] <= rd_data;
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
    end
  end

  always_ff @(posedge lcd_pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_req_d <= 1'b0;
      r_pixel_data <= '0;
      r_synced     <= 1'b0;
      r_underflow  <= 1'b0;
      r_consumed   <= '0;
    end else begin
      r_data_req_d <= data_req;
      if (data_req) r_pixel_data <= w_pop ? r_mem[r_rd_ptr] : UNDERFLOW_COLOR;
      if (w_flush || w_underflow) r_synced <= 1'b0;
      else if (w_sync_now)        r_synced <= 1'b1;
      if (w_underflow)  r_underflow <= 1'b1;
      else if (err_clr) r_underflow <= 1'b0;
      if (w_flush || w_frame_end) r_consumed <= '0;
      else if (w_pop)             r_consumed <= r_consumed + 21'd1;
    end
  end

  assign pixel_data = r_pixel_data;
  assign rd_req     = r_rd_req;
  assign rd_addr    = r_rd_addr;
  assign rd_len     = r_rd_len;
  assign synced     = r_synced;
  assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: doc/lcd_line_fetch.md
Name: lcd_line_fetch

Overview:
- Pixel-fetch scheduler sitting between a shared frame-buffer read port and the RGB LCD timing driver.
- Requests pixels from memory in bursts and buffers them in an internal FIFO, keeping ahead of the display by prefetching during blanking.
- Serves one pixel per `data_req` so that `pixel_data` is valid in the driver's `lcd_de` cycle.
- Tracks frame alignment and recovers from underflow by resynchronising at the next frame start.

Parameters:
- ADDR_W, 28: memory address width, in pixel-word units.
- FIFO_DEPTH, 512: pixel FIFO depth; must be a power of two and at least 2*BURST_LEN.
- BURST_LEN, 64: maximum pixels per read burst.
- UNDERFLOW_COLOR, 24'h000000: pixel value driven whenever no valid pixel can be served.

Ports:
- lcd_pclk  in  1  pixel clock.
- rst_n  in  1  reset.
- fetch_en  in  1  fetch enable, level-sensitive.
- frame_base  in  ADDR_W  frame buffer base address, sampled at producer frame start.
- h_disp  in  11  active pixels per line.
- v_disp  in  11  active lines per frame.
- data_req  in  1  pixel request from the timing driver.
- pixel_ypos  in  11  driver line index; equals 1 throughout the first active line.
- pixel_data  out  24  pixel to the driver.
- rd_req  out  1  burst request.
- rd_addr  out  ADDR_W  burst start address.
- rd_len  out  8  burst length in pixels, 1..BURST_LEN.
- rd_grant  in  1  one-cycle acceptance of `rd_req`.
- rd_valid  in  1  read data beat valid.
- rd_data  in  24  read data beat.
- synced  out  1  consumer is frame-aligned.
- underflow  out  1  sticky error flag.
- err_clr  in  1  clears `underflow`.

Interface decision:
- Reset is `rst_n`: asynchronous, active-low.
- Clock is `lcd_pclk`.
- All logic is in the single clock domain `lcd_pclk`.

Behaviour:

Reset values:
- Outputs: `pixel_data`=0, `rd_req`=0, `rd_addr`=0, `rd_len`=0, `synced`=0, `underflow`=0.
- FIFO is empty, all counters are 0, and the producer FSM is in IDLE.

Frame size:
- FRAME_PIX = `h_disp` * `v_disp`, computed with 21-bit arithmetic.

Producer FSM (IDLE, REQ, DATA, RESYNC):
- IDLE -> REQ when `fetch_en`=1 and `fetched` < FRAME_PIX and free space ≥ `rd_len`. Free space is FIFO_DEPTH minus the FIFO count.
- Burst parameters on entering REQ:
  - `rd_len` = min(BURST_LEN, FRAME_PIX − `fetched`).
  - `rd_addr` = `frame_base_q` + `fetched`.
  - `frame_base_q` is latched from `frame_base` whenever `fetched`=0.
- REQ: hold `rd_req`=1 and keep `rd_addr`/`rd_len` stable until `rd_grant`. On grant, `rd_req` drops the next cycle and the FSM goes to DATA.
- DATA: accept exactly `rd_len` beats. Beats may be non-contiguous. Each `rd_valid` writes `rd_data` into the FIFO. After the last beat, add `rd_len` to `fetched` and return to IDLE.
- At most one burst is outstanding.
- The FIFO cannot overflow, because space is reserved before the request is issued.
- When `fetched` = FRAME_PIX, no further requests are made until the consumer reaches frame end. At frame end, `fetched` is cleared, which starts prefetch of the next frame during vertical blanking.
- `fetch_en` low:
  - No new request is issued; any outstanding burst completes.
  - Then the FIFO is flushed, `fetched` and `consumed` are cleared, and `synced` is cleared.

Consumer:
- Frame-start event: rising edge of `data_req` while `pixel_ypos`=1.
- Synchronisation on a frame-start event with `fetch_en`=1:
  - If `synced`=0: set `synced`=1.
  - If `synced`=1 and `consumed` ≠ 0: misalignment, treated exactly like an underflow.
- `data_req`=1 with `synced`=1 and FIFO non-empty: pop the FIFO, `pixel_data` = popped word on the next cycle, and increment `consumed`.
- When `consumed` reaches FRAME_PIX: clear `consumed` and clear `fetched` in the same cycle.
- `data_req`=1 with `synced`=0: `pixel_data` = UNDERFLOW_COLOR next cycle, with no flag.
- `data_req`=1 with `synced`=1 and FIFO empty (underflow):
  - `pixel_data` = UNDERFLOW_COLOR next cycle.
  - Set `underflow`, clear `synced`, and move the producer to RESYNC.
- RESYNC: wait for any outstanding burst to complete, discarding its beats. Then flush the FIFO, clear `fetched` and `consumed`, and go to IDLE. Fetching restarts at `frame_base` and the consumer realigns on the next frame start.
- `pixel_data` holds its last value when `data_req`=0.

Timing and flag rules:
- Latency from `data_req` to `pixel_data` is exactly 1 cycle.
- A FIFO push and pop in the same cycle are both honoured.
- `err_clr` clears `underflow`; if a new underflow occurs in the same cycle, set wins.

Test Plan:
1. Small frame, full prefetch: FIFO_DEPTH=16, BURST_LEN=4, `h_disp`=8, `v_disp`=2, `frame_base`=0x100, grant immediately with back-to-back data, `fetch_en`=1.
   - Required: bursts issued at addr 0x100, 0x104, 0x108 and 0x10C, each with len 4.
   - Required: once `synced` after the first frame start, the 16 pixels appear in order, each one cycle after its `data_req`.
   - Required: `underflow` stays 0.
2. Short last burst: `h_disp`=6, `v_disp`=1, BURST_LEN=4.
   - Required: bursts are addr base with len 4, then base+4 with len 2.
   - Required: the next frame refetches from base after 6 pixels are consumed.
3. Grant stall: hold `rd_grant`=0 for 20 cycles.
   - Required: `rd_req`, `rd_addr` and `rd_len` stay stable throughout.
   - Required: only one burst is issued after the grant.
4. Underflow recovery: withhold `rd_valid` mid-frame.
   - Required: on `data_req` with the FIFO empty, `pixel_data`=UNDERFLOW_COLOR and `underflow`=1 and `synced`=0.
   - Required: the late beats are discarded and refetch restarts at base.
   - Required: correct pixels are served after the next frame start; `err_clr` clears `underflow`.
5. Enable toggle: drop `fetch_en` mid-burst.
   - Required: the burst completes, then the FIFO is flushed and `synced`=0.
   - Required: `data_req` gets UNDERFLOW_COLOR with `underflow` remaining 0.
   - Required: after re-enabling, prefetch starts at base and syncs at the next `pixel_ypos`=1 rising `data_req`.
6. Reset mid-DATA:
   - Required: `rd_req`=0, `pixel_data`=0, `synced`=0 and the FIFO is empty immediately.
   - Required: there is no stray FIFO write after reset is released.
